fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-side scheduler for the parameterised FIFO. Shares the FIFO's single write port (`wen`/`din`, PAR_WRITE words per beat) between NUM_REQ producers. Grants bounded bursts and honours FIFO back-pressure via `ready`. Also sequences the FIFO `clear` pulse so that it never lands in the middle of a granted beat.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 8: bits per FIFO word.
- `PAR_WRITE`, 1: words per write beat; must match the FIFO's PAR_WRITE.
- `MAX_BURST`, 4: maximum beats per grant, 1..16.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-producer request, level. Held while the producer has a beat to write.
- `req_data`  in  NUM_REQ*PAR_WRITE*DATA_WIDTH  beat data. Slice i belongs to producer i.
- `gnt`  out  NUM_REQ  one-hot beat-accept strobe. Producer i's beat is consumed at the edge where `gnt[i]`=1.
- `owner`  out  clog2(NUM_REQ)  current grant holder; 0 when idle.
- `fifo_ready`  in  1  FIFO `ready`; 1 means a write beat is accepted this cycle.
- `fifo_wen`  out  1  FIFO write enable.
- `fifo_din`  out  PAR_WRITE*DATA_WIDTH  FIFO write data.
- `clear_req`  in  1  request to flush the FIFO, level, sampled each cycle.
- `fifo_clear`  out  1  FIFO `clear`.
- `clear_done`  out  1  one-cycle pulse when the flush has been issued.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner fixed, beats flow.
  - CLEAR: single cycle.
- IDLE:
  - `clear_req`=1 → CLEAR. Clear has priority over any `req`.
  - Otherwise, if any `req` is set, the winner is the first set bit scanning upward (mod NUM_REQ) from `rr_ptr`. Then `owner`←winner, `burst_cnt`←0 → OWN.
  - No grant is issued in IDLE.
- OWN:
  - `gnt[owner]` = `req[owner]` & `fifo_ready` & !`clear_req`; all other `gnt` bits are 0.
  - An accepted beat increments `burst_cnt`.
  - Exit to IDLE with `rr_ptr`←owner+1 (mod NUM_REQ) when either:
    - `req[owner]`=0, or
    - a beat is accepted with `burst_cnt`=MAX_BURST−1.
  - `clear_req`=1 → CLEAR. No beat is accepted in that cycle.
  - `fifo_ready`=0 stalls: state and count are held, `gnt`=0.
- CLEAR:
  - `fifo_clear`=1 and `clear_done`=1 for exactly one cycle, then IDLE.
  - `rr_ptr`←0.
  - Requests are ignored.
- Datapath, combinational:
  - `fifo_wen` = |`gnt`.
  - `fifo_din` = `req_data` slice[owner] when `fifo_wen`=1, else 0.
- A producer must not change its data slice while `req` is high and `gnt` is low.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0, `burst_cnt` 0. `gnt`, `fifo_wen`, `fifo_din`, `fifo_clear`, `clear_done`, `busy` are all 0.
- Arbitration latency: first `gnt` comes 1 cycle after `req` rises in IDLE. When the FIFO is ready, the next beats follow back-to-back.
- Re-arbitration gap: 1 IDLE cycle between consecutive grants, including a burst-end followed by the same producer re-requesting.
- Clear latency: `fifo_clear` comes 1 cycle after `clear_req` is sampled in IDLE or OWN. A beat in flight is never split; because the write is combinational, the gate on `clear_req` is sufficient.
- If `clear_req` is held high, CLEAR repeats every other cycle (CLEAR, IDLE, CLEAR, ...).
- `rst` asserted mid-burst: outputs drop to their reset values immediately (asynchronously). The partially written burst is not resumed.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `grant_cnt` (NUM_REQ*16): per-producer count of accepted beats.
  - Counters saturate at 16'hFFFF.
  - Zeroed by `rst` and in the CLEAR cycle.
- Undefined: the port and the counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `fifo_arb_pkg`:
  - state enum (IDLE, OWN, CLEAR);
  - `CNT_W`=16;
  - function `rr_pick(req, ptr)` returning the winner index.
- Sub-module `rr_picker`: purely combinational rotate / priority-encode / unrotate, parameterised by NUM_REQ. The FSM, counters and data mux stay in the top.

## Test plan
- Single producer: `req`=4'b0010, `fifo_ready`=1, data 8'd1..8'd6 → `gnt[1]` for 4 beats (1–4). 1 idle cycle, then a second grant for 5–6. `fifo_din` = 1,2,3,4,5,6.
- Round-robin: `req`=4'b1111 held → owners 0,1,2,3,0, each for 4 beats with a 1-cycle gap. No producer is granted twice before all others.
- Back-pressure: owner 2 mid-burst, `fifo_ready`=0 for 3 cycles → `gnt`=0 and `fifo_wen`=0 for those cycles. On release the burst resumes at the same `burst_cnt`; 4 beats total.
- Clear priority: in IDLE, `clear_req`=1 and `req`=4'b0001 together → next cycle `fifo_clear`=`clear_done`=1 with no `gnt`; grant to 0 two cycles later.
- Clear mid-burst: owner 3 after 2 beats, `clear_req` pulse → no beat accepted that cycle, `fifo_clear` on the next cycle, `rr_ptr`=0. With `FIFO_ARB_STATS_EN` defined, `grant_cnt` reads 0.
- Async reset: `rst` asserted between clock edges during OWN → `gnt`, `fifo_wen`, `busy` go to 0 without waiting for an edge. After release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional per-producer beat statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // Round-robin winner among the low n bits of req, scanning upward from ptr.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n = 8);
    logic [7:0]  rot;
    logic [2:0]  k;
    int unsigned idx;
    rot = '0;
    k   = '0;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) begin
        idx    = (32'(ptr) + i) % n;
        rot[i] = req[idx[2:0]];
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) k = 3'(i);
    end
    return 3'((32'(ptr) + 32'(k)) % n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate by pointer, priority-encode, unrotate.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  always_comb begin
    winner = OW'(rr_pick(8'(req), 3'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin scheduler sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add the per-producer grant_cnt output.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ*PAR_WRITE*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                     gnt,
  output logic [$clog2(NUM_REQ)-1:0]             owner,
  input  logic                                   fifo_ready,
  output logic                                   fifo_wen,
  output logic [PAR_WRITE*DATA_WIDTH-1:0]        fifo_din,
  input  logic                                   clear_req,
  output logic                                   fifo_clear,
  output logic                                   clear_done,
  output logic                                   busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]               grant_cnt
`endif
);

  localparam int unsigned OW     = $clog2(NUM_REQ);
  localparam int unsigned BW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned BEAT_W = PAR_WRITE * DATA_WIDTH;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [OW-1:0] pick;
  logic [OW-1:0] ptr_next;
  logic          req_own;
  logic          accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  assign req_own  = req[owner_q];
  assign ptr_next = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
  // The clear_req gate keeps a beat from being accepted in the cycle a flush is taken.
  assign accept   = (state_q == ST_OWN) && req_own && fifo_ready && !clear_req;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (|req) begin
          owner_d = pick;
          burst_d = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (!req_own) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next;
        end else if (fifo_ready) begin
          if (burst_q == BW'(MAX_BURST - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = ptr_next;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt        = accept ? (NUM_REQ'(1) << owner_q) : '0;
    fifo_wen   = accept;
    owner      = (state_q == ST_OWN) ? owner_q : '0;
    fifo_clear = (state_q == ST_CLEAR);
    clear_done = (state_q == ST_CLEAR);
    busy       = (state_q != ST_IDLE);
    fifo_din   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && owner_q == OW'(i)) fifo_din = req_data[i*BEAT_W +: BEAT_W];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  // Saturating accepted-beat counters, flushed together with the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state_d == ST_CLEAR || state_q == ST_CLEAR) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && cnt_q[i] != {CNT_W{1'b1}}) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (default parameters).
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        fifo_ready;
  logic        fifo_wen;
  logic [7:0]  fifo_din;
  logic        clear_req;
  logic        fifo_clear;
  logic        clear_done;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .owner      (owner),
    .fifo_ready (fifo_ready),
    .fifo_wen   (fifo_wen),
    .fifo_din   (fifo_din),
    .clear_req  (clear_req),
    .fifo_clear (fifo_clear),
    .clear_done (clear_done),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int p, input logic [7:0] v);
    req_data[p*8 +: 8] = v;
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    fifo_ready = 1'b1;
    clear_req  = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wen", 32'(fifo_wen), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_clear", 32'(fifo_clear), 32'h0);
    chk("rst_done", 32'(clear_done), 32'h0);
    chk("rst_din", 32'(fifo_din), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Single producer 1: beats 1..4, one idle gap, then 5..6.
    req = 4'b0010;
    set_data(1, 8'd1);
    #1;
    chk("s1_idle_gnt", 32'(gnt), 32'h0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      set_data(1, 8'(k));
      #1;
      if (k == 5) begin
        chk("s1_gap_gnt", 32'(gnt), 32'h0);
        chk("s1_gap_busy", 32'(busy), 32'h0);
        tick();
      end
      chk("s1_gnt", 32'(gnt), 32'h2);
      chk("s1_owner", 32'(owner), 32'h1);
      chk("s1_din", 32'(fifo_din), 32'(k));
      tick();
    end
    req = 4'b0000;
    #1;
    chk("s1_drop_gnt", 32'(gnt), 32'h0);
    tick();
    chk("s1_end_busy", 32'(busy), 32'h0);

    // Clear pulse in IDLE resets the round-robin pointer to 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    #1;
    chk("c0_clear", 32'(fifo_clear), 32'h1);
    tick();

    // Round-robin with all four requesting: owners 0,1,2,3,0.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_gap_gnt", 32'(gnt), 32'h0);
      tick();
      for (int b = 0; b < 4; b++) begin
        chk("rr_owner", 32'(owner), 32'(g % 4));
        chk("rr_gnt", 32'(gnt), 32'(1 << (g % 4)));
        chk("rr_din", 32'(fifo_din), 32'(8'hA0 + (g % 4)));
        tick();
      end
    end
    req = 4'b0000;
    #1;
    chk("rr_end_busy", 32'(busy), 32'h0);

    // Back-pressure on owner 2 after two beats; burst still totals four beats.
    req = 4'b0100;
    set_data(2, 8'h5C);
    tick();
    for (int b = 0; b < 2; b++) begin
      chk("bp_pre_gnt", 32'(gnt), 32'h4);
      tick();
    end
    fifo_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_stall_gnt", 32'(gnt), 32'h0);
      chk("bp_stall_wen", 32'(fifo_wen), 32'h0);
      chk("bp_stall_owner", 32'(owner), 32'h2);
      tick();
    end
    fifo_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("bp_post_gnt", 32'(gnt), 32'h4);
      tick();
    end
    chk("bp_end_busy", 32'(busy), 32'h0);
    req = 4'b0000;

    // Clear has priority over a simultaneous request in IDLE.
    clear_req = 1'b1;
    req       = 4'b0001;
    #1;
    chk("cp_idle_gnt", 32'(gnt), 32'h0);
    tick();
    clear_req = 1'b0;
    #1;
    chk("cp_clear", 32'(fifo_clear), 32'h1);
    chk("cp_done", 32'(clear_done), 32'h1);
    chk("cp_gnt", 32'(gnt), 32'h0);
    tick();
    chk("cp_after_clear", 32'(fifo_clear), 32'h0);
    chk("cp_after_gnt", 32'(gnt), 32'h0);
    tick();
    chk("cp_grant0", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();

    // Clear in the middle of owner 3's burst.
    req = 4'b1000;
    set_data(3, 8'h33);
    tick();
    for (int b = 0; b < 2; b++) begin
      chk("cm_pre_gnt", 32'(gnt), 32'h8);
      tick();
    end
`ifdef FIFO_ARB_STATS_EN
    chk("cm_stat_pre", 32'(grant_cnt[63:48]), 32'h2);
`endif
    clear_req = 1'b1;
    #1;
    chk("cm_gate_gnt", 32'(gnt), 32'h0);
    chk("cm_gate_wen", 32'(fifo_wen), 32'h0);
    tick();
    clear_req = 1'b0;
    #1;
    chk("cm_clear", 32'(fifo_clear), 32'h1);
    chk("cm_done", 32'(clear_done), 32'h1);
    tick();
`ifdef FIFO_ARB_STATS_EN
    chk("cm_stat_zero", 32'(grant_cnt), 32'h0);
`endif
    // Pointer is 0 after the clear, so producer 0 beats producer 3.
    req = 4'b1001;
    tick();
    chk("cm_ptr_owner", 32'(owner), 32'h0);
    chk("cm_ptr_gnt", 32'(gnt), 32'h1);
    tick();
    req = 4'b1000;
    #1;
    chk("ar_drop_gnt", 32'(gnt), 32'h0);
    tick();
    tick();
    chk("ar_own3", 32'(gnt), 32'h8);

    // Asynchronous reset mid-cycle during OWN.
    req = 4'b1010;
    #1;
    chk("ar_pre_gnt", 32'(gnt), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_wen", 32'(fifo_wen), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_owner", 32'(owner), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("ar_idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("ar_first_owner", 32'(owner), 32'h1);
    chk("ar_first_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
